irq_ctrl: RTL

- Interrupt controller that sits between the interrupt sources and the CPU core.
- Sources include the debounced button soft-interrupt pulse, timer and UART events.
- Latches single-cycle event pulses into pending bits, applies a CPU-writable enable mask and picks one source by fixed priority.
- Presents the chosen source to the core with an irq/ack/eoi handshake, so only one interrupt is in service at a time.

---
 rtl/irq_ctrl_pkg.sv | 16 +
 rtl/irq_ctrl_prio_enc.sv | 21 ++
 rtl/irq_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
// Holds the handshake state encoding and the fixed source assignments.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_t;

  localparam int SRC_BUTTON  = 0;
  localparam int SRC_TIMER   = 1;
  localparam int SRC_UART_RX = 2;
  localparam int SRC_UART_TX = 3;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Fixed-priority encoder: reports the lowest set bit of i_vec.
// Bit 0 has the highest priority.
module irq_prio_enc #(
  parameter int NSRC = 4,
  parameter int CW   = 2
) (
  input  logic [NSRC-1:0] i_vec,
  output logic            o_valid,
  output logic [CW-1:0]   o_idx
);

  always_comb begin
    o_valid = |i_vec;
    o_idx   = '0;
    // Scan from the top down so the lowest set index is written last.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = CW'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches event pulses, masks them, picks one by fixed
// priority and hands it to the core with an irq/ack/eoi handshake.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int              NSRC     = 4,
  parameter int              CW       = 2,
  parameter logic [NSRC-1:0] RST_MASK = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NSRC-1:0] i_src_pulse,
  input  logic            i_mask_we,
  input  logic [NSRC-1:0] i_mask_wdata,
  output logic [NSRC-1:0] o_mask,
  output logic [NSRC-1:0] o_pending,
  output logic [NSRC-1:0] o_ovf,
  input  logic            i_ovf_clr,
  output logic            o_irq,
  output logic [CW-1:0]   o_cause,
  input  logic            i_ack,
  input  logic            i_eoi,
  output logic            o_busy
);

  irq_state_t      r_state;
  irq_state_t      w_state_nxt;
  logic            r_irq;
  logic            w_irq_nxt;
  logic [CW-1:0]   r_cause;
  logic [CW-1:0]   w_cause_nxt;
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] r_pending;
  logic [NSRC-1:0] r_ovf;
  logic [NSRC-1:0] w_eligible;
  logic [NSRC-1:0] w_clr;
  logic            w_ack_take;
  logic            w_valid;
  logic [CW-1:0]   w_win;

  assign w_eligible = r_pending & r_mask;

  irq_prio_enc #(
    .NSRC (NSRC),
    .CW   (CW)
  ) u_prio_enc (
    .i_vec   (w_eligible),
    .o_valid (w_valid),
    .o_idx   (w_win)
  );

  assign w_clr = w_ack_take ? ({{(NSRC-1){1'b0}}, 1'b1} << r_cause) : '0;

  // A new pulse is OR-ed in after the ack clear, so a coinciding event survives.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mask    <= RST_MASK;
      r_pending <= '0;
      r_ovf     <= '0;
    end else begin
      if (i_mask_we) r_mask <= i_mask_wdata;
      r_pending <= (r_pending & ~w_clr) | i_src_pulse;
      r_ovf     <= (i_ovf_clr ? '0 : r_ovf) | (i_src_pulse & r_pending);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_irq   <= 1'b0;
      r_cause <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_irq   <= w_irq_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_irq_nxt   = r_irq;
    w_cause_nxt = r_cause;
    w_ack_take  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_state_nxt = ST_ASSERT;
          w_irq_nxt   = 1'b1;
          w_cause_nxt = w_win;
        end
      end
      ST_ASSERT: begin
        // Ack beats withdrawal when the source is masked off in the same cycle.
        if (i_ack) begin
          w_ack_take  = 1'b1;
          w_state_nxt = ST_SERVICE;
          w_irq_nxt   = 1'b0;
        end else if (!r_mask[r_cause]) begin
          w_state_nxt = ST_IDLE;
          w_irq_nxt   = 1'b0;
        end
      end
      ST_SERVICE: begin
        if (i_eoi) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_irq_nxt   = 1'b0;
      end
    endcase
  end

  assign o_mask    = r_mask;
  assign o_pending = r_pending;
  assign o_ovf     = r_ovf;
  assign o_irq     = r_irq;
  assign o_cause   = r_cause;
  assign o_busy    = (r_state != ST_IDLE);

endmodule
